multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
// - Multi-cycle sequencer for the ARM-subset processor datapath: replaces the single-cycle decoder.
// - Moore FSM that walks each instruction through FETCH/DECODE/EXECUTE/MEM/WB.
// - Drives all datapath selects and write strobes, and holds the NZCV flag register.
// - Sits beside the multi-cycle datapath under the processor top level; takes the IR contents and the ALU flags.
// PARAMETERS
// - ADD_CODE  4'b0100  ALU command used for PC increment and address add
// - SUB_CODE  4'b0010  ALU command used for negative-offset address (U=0)
// - MOV_CODE  4'b1101  ALU command that passes SrcB (BX target)
// - CMP_CODE  4'b1010  data-processing cmd with no register write-back
// PORTS
// - clk          in   1   rising-edge clock
// - reset        in   1   synchronous, active-high reset
// - instr        in   32  IR output (stable from DECODE onward)
// - alu_flags    in   4   combinational NZCV from ALU {N,Z,C,V}
// - pc_write     out  1   PC register load strobe
// - adr_src      out  1   memory address: 0 = PC, 1 = ALUOut
// - mem_write    out  1   data-memory write strobe
// - ir_write     out  1   IR load strobe
// - result_src   out  2   00 = ALUOut, 01 = mem data, 10 = ALU result (direct)
// - alu_src_a    out  1   0 = RD1 reg, 1 = PC
// - alu_src_b    out  2   00 = shifted RD2, 01 = ext imm, 10 = const 4
// - alu_control  out  4   ARM cmd code to ALU
// - imm_src      out  2   00 = imm8 (DP), 01 = imm12 (LDR/STR), 10 = imm24<<2 (B)
// - reg_src      out  2   [0] RA1 = R15, [1] RA2 = Rm (instr[3:0]) rather than Rd
// - reg_write    out  1   register-file write strobe
// - shift_ctrl   out  2   shifter type (instr[6:5] in EXECR, else 00)
// - shamt        out  5   shift amount (instr[11:7] in EXECR, else 0)
// - flags_q      out  4   registered NZCV
// - state_dbg    out  4   current state code
// BEHAVIOUR
// - States (4-bit codes): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECR 6, EXECI 7,
//   ALUWB 8, BRANCH 9, BX 10. Unused codes go to FETCH.
// - Reset: in the cycle reset is high, all strobes (pc_write, ir_write, mem_write, reg_write) = 0.
//   Next state = FETCH, flags_q = 0. A reset mid-instruction aborts it; no write occurs in that cycle.
// - Unlisted outputs = 0 in every state.
// - FETCH: ir_write=1, pc_write=1, adr_src=0, alu_src_a=1, alu_src_b=10, alu_control=ADD, result_src=10. Next: DECODE.
// - DECODE: alu_src_a=1, alu_src_b=10, ADD, result_src=10 (PC+8 visible on R15 read); reg_src[0]=1 if op=10.
//   cond_ex = ARM condition (instr[31:28]) evaluated against flags_q; cond 1111 treated as false.
//   Next:
//     - !cond_ex -> FETCH
//     - instr[27:4]==24'h12FFF1 -> BX
//     - op=01 -> MEMADR
//     - op=00 & I=0 -> EXECR
//     - op=00 & I=1 -> EXECI
//     - op=10 -> BRANCH
//     - op=11 -> FETCH (NOP)
// - MEMADR: alu_src_b=01, imm_src=01, alu_control = U(instr[23]) ? ADD : SUB.
//   Next: L(instr[20]) ? MEMRD : MEMWR.
// - MEMRD: adr_src=1. Next: MEMWB.
// - MEMWB: result_src=01, reg_write=1, pc_write=(Rd==15). Next: FETCH.
// - MEMWR: adr_src=1, mem_write=1. Next: FETCH.
// - EXECR: alu_src_b=00, alu_control=instr[24:21], shift_ctrl=instr[6:5], shamt=instr[11:7].
// - EXECI: alu_src_b=01, imm_src=00, alu_control=instr[24:21].
// - EXECR/EXECI: at the clock edge, flags_q <= alu_flags iff S(instr[20])=1. Next: ALUWB.
// - ALUWB: result_src=00, reg_write = (instr[24:21]!=CMP_CODE), pc_write = reg_write & (Rd==15). Next: FETCH.
// - BRANCH: reg_src[0]=1, alu_src_a=0, alu_src_b=01, imm_src=10, ADD, result_src=10, pc_write=1.
//   L bit is ignored (no link). Next: FETCH.
// - BX: reg_src[1]=1, alu_src_b=00, alu_control=MOV, result_src=10, pc_write=1. Next: FETCH.
// - CPI: DP = 4 cycles, LDR = 5, STR = 4, B/BX = 3, failed condition = 2.
// STRUCTURE
// - Shared package/header: state codes, ALU cmd codes, result_src/imm_src/alu_src_b encodings, BX pattern.
// - One sub-module, cond_check: combinational (cond[3:0], NZCV) -> cond_ex.
// - The FSM next-state logic and output decode stay in this module.
// TESTING
// - Reset, then ADD R1,R2,R3 (0xE0821003):
//   - states 0,1,6,8,0
//   - reg_write=1 only in ALUWB
//   - alu_control=0100 in EXECR
// - SUBS R1,R2,R3 (0xE0521003), alu_flags=4'b0100 in EXECR:
//   - flags_q=0100 from the ALUWB cycle onward
//   - then BEQ 0x0A000002 runs states 0,1,9 with pc_write=1 in BRANCH
// - LDR R0,[R1,#4] (0xE5910004):
//   - states 0,1,2,3,4
//   - adr_src=1 in MEMRD
//   - result_src=01 and reg_write=1 in MEMWB
// - STR R0,[R1,#4] (0xE5810004):
//   - states 0,1,2,5
//   - mem_write=1 for exactly one cycle
//   - reg_write never 1
// - BEQ 0x0A000002 with flags_q=0000:
//   - DECODE -> FETCH
//   - no pc_write outside FETCH
//   - BX LR (0xE12FFF1E) runs states 0,1,10 with reg_src=10
// - Assert reset during MEMWR:
//   - mem_write=0 in that cycle
//   - state_dbg=0 on the next cycle
//   - flags_q=0

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multi-cycle ARM-subset controller: state codes,
// ALU command codes, datapath select encodings and the BX instruction pattern.
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_BX     = 4'd10
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_MOV = 4'b1101;
  localparam logic [3:0] ALU_CMP = 4'b1010;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] IMM_DP  = 2'b00;
  localparam logic [1:0] IMM_MEM = 2'b01;
  localparam logic [1:0] IMM_BR  = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [23:0] BX_PATTERN = 24'h12FFF1;

endpackage

// File: rtl/multicycle_controller_cond_check.sv
// ARM condition-code evaluation against NZCV; the reserved code 1111 never executes.
module multicycle_controller_cond_check (
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       cond_ex_o
);

  logic n, z, c, v;
  assign {n, z, c, v} = flags_i;

  always_comb begin
    cond_ex_o = 1'b0;
    case (cond_i)
      4'b0000: cond_ex_o = z;
      4'b0001: cond_ex_o = ~z;
      4'b0010: cond_ex_o = c;
      4'b0011: cond_ex_o = ~c;
      4'b0100: cond_ex_o = n;
      4'b0101: cond_ex_o = ~n;
      4'b0110: cond_ex_o = v;
      4'b0111: cond_ex_o = ~v;
      4'b1000: cond_ex_o = c & ~z;
      4'b1001: cond_ex_o = ~c | z;
      4'b1010: cond_ex_o = (n == v);
      4'b1011: cond_ex_o = (n != v);
      4'b1100: cond_ex_o = ~z & (n == v);
      4'b1101: cond_ex_o = z | (n != v);
      4'b1110: cond_ex_o = 1'b1;
      default: cond_ex_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore sequencer walking each instruction through FETCH/DECODE/EXECUTE/MEM/WB,
// driving all datapath selects and strobes and holding the NZCV flag register.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter logic [3:0] ADD_CODE = ALU_ADD,
  parameter logic [3:0] SUB_CODE = ALU_SUB,
  parameter logic [3:0] MOV_CODE = ALU_MOV,
  parameter logic [3:0] CMP_CODE = ALU_CMP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic [3:0]  alu_flags,
  output logic        pc_write,
  output logic        adr_src,
  output logic        mem_write,
  output logic        ir_write,
  output logic [1:0]  result_src,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [3:0]  alu_control,
  output logic [1:0]  imm_src,
  output logic [1:0]  reg_src,
  output logic        reg_write,
  output logic [1:0]  shift_ctrl,
  output logic [4:0]  shamt,
  output logic [3:0]  flags_q,
  output logic [3:0]  state_dbg
);

  state_t state_q, state_d;
  logic   cond_ex;
  logic   unused_instr_bits;

  logic [1:0] op;
  logic       imm_bit, u_bit, l_bit, s_bit, rd_is_pc, wb_en;
  logic [3:0] cmd;

  assign op       = instr[27:26];
  assign imm_bit  = instr[25];
  assign cmd      = instr[24:21];
  assign u_bit    = instr[23];
  assign l_bit    = instr[20];
  assign s_bit    = instr[20];
  assign rd_is_pc = (instr[15:12] == 4'd15);
  assign wb_en    = (cmd != CMP_CODE);
  assign unused_instr_bits = ^instr[3:0];

  multicycle_controller_cond_check u_cond_check (
    .cond_i    (instr[31:28]),
    .flags_i   (flags_q),
    .cond_ex_o (cond_ex)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      flags_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      if ((state_q == S_EXECR || state_q == S_EXECI) && s_bit)
        flags_q <= alu_flags;
    end
  end

  assign state_dbg = state_q;

  always_comb begin
    state_d     = S_FETCH;
    pc_write    = 1'b0;
    adr_src     = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    result_src  = RES_ALUOUT;
    alu_src_a   = 1'b0;
    alu_src_b   = SRCB_REG;
    alu_control = 4'b0000;
    imm_src     = IMM_DP;
    reg_src     = 2'b00;
    reg_write   = 1'b0;
    shift_ctrl  = 2'b00;
    shamt       = 5'd0;

    case (state_q)
      S_FETCH: begin
        ir_write    = 1'b1;
        pc_write    = 1'b1;
        alu_src_a   = 1'b1;
        alu_src_b   = SRCB_FOUR;
        alu_control = ADD_CODE;
        result_src  = RES_ALU;
        state_d     = S_DECODE;
      end
      S_DECODE: begin
        // PC+4 is computed again here so R15 reads see PC+8
        alu_src_a   = 1'b1;
        alu_src_b   = SRCB_FOUR;
        alu_control = ADD_CODE;
        result_src  = RES_ALU;
        reg_src[0]  = (op == 2'b10);
        if (!cond_ex)                        state_d = S_FETCH;
        else if (instr[27:4] == BX_PATTERN)  state_d = S_BX;
        else if (op == 2'b01)                state_d = S_MEMADR;
        else if (op == 2'b00)                state_d = imm_bit ? S_EXECI : S_EXECR;
        else if (op == 2'b10)                state_d = S_BRANCH;
        else                                 state_d = S_FETCH;
      end
      S_MEMADR: begin
        alu_src_b   = SRCB_IMM;
        imm_src     = IMM_MEM;
        alu_control = u_bit ? ADD_CODE : SUB_CODE;
        state_d     = l_bit ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        adr_src = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_MEM;
        reg_write  = 1'b1;
        pc_write   = rd_is_pc;
      end
      S_MEMWR: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECR: begin
        alu_src_b   = SRCB_REG;
        alu_control = cmd;
        shift_ctrl  = instr[6:5];
        shamt       = instr[11:7];
        state_d     = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_b   = SRCB_IMM;
        imm_src     = IMM_DP;
        alu_control = cmd;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        result_src = RES_ALUOUT;
        reg_write  = wb_en;
        pc_write   = wb_en & rd_is_pc;
      end
      S_BRANCH: begin
        reg_src[0]  = 1'b1;
        alu_src_a   = 1'b0;
        alu_src_b   = SRCB_IMM;
        imm_src     = IMM_BR;
        alu_control = ADD_CODE;
        result_src  = RES_ALU;
        pc_write    = 1'b1;
      end
      S_BX: begin
        reg_src[1]  = 1'b1;
        alu_src_b   = SRCB_REG;
        alu_control = MOV_CODE;
        result_src  = RES_ALU;
        pc_write    = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase

    // Reset aborts the instruction in flight: nothing is written this cycle
    if (reset) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      state_d   = S_FETCH;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks hand-decoded instructions
// through the FSM and checks state codes, selects, strobes and flags per cycle.
module tb_multicycle_controller;

  logic        clk;
  logic        reset;
  logic [31:0] instr;
  logic [3:0]  alu_flags;
  logic        pc_write, adr_src, mem_write, ir_write, alu_src_a, reg_write;
  logic [1:0]  result_src, alu_src_b, imm_src, reg_src, shift_ctrl;
  logic [3:0]  alu_control, flags_q, state_dbg;
  logic [4:0]  shamt;

  int n_cmp = 0;
  int n_err = 0;

  multicycle_controller dut (
    .clk         (clk),
    .reset       (reset),
    .instr       (instr),
    .alu_flags   (alu_flags),
    .pc_write    (pc_write),
    .adr_src     (adr_src),
    .mem_write   (mem_write),
    .ir_write    (ir_write),
    .result_src  (result_src),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_control (alu_control),
    .imm_src     (imm_src),
    .reg_src     (reg_src),
    .reg_write   (reg_write),
    .shift_ctrl  (shift_ctrl),
    .shamt       (shamt),
    .flags_q     (flags_q),
    .state_dbg   (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    reset     = 1'b1;
    instr     = 32'h0;
    alu_flags = 4'b0000;

    // Reset cycle: state forced to FETCH, strobes suppressed
    tick();
    check("rst_state", state_dbg, 4'd0);
    check("rst_ir_write", ir_write, 1'b0);
    check("rst_pc_write", pc_write, 1'b0);
    check("rst_flags", flags_q, 4'b0000);
    reset = 1'b0;
    #1;

    // ADD R1,R2,R3
    instr = 32'hE0821003;
    alu_flags = 4'b1111;
    check("add_fetch_state", state_dbg, 4'd0);
    check("add_fetch_ir_write", ir_write, 1'b1);
    check("add_fetch_pc_write", pc_write, 1'b1);
    check("add_fetch_srcb", alu_src_b, 2'b10);
    tick();
    check("add_decode_state", state_dbg, 4'd1);
    check("add_decode_reg_write", reg_write, 1'b0);
    tick();
    check("add_execr_state", state_dbg, 4'd6);
    check("add_execr_alu_control", alu_control, 4'b0100);
    check("add_execr_reg_write", reg_write, 1'b0);
    tick();
    check("add_aluwb_state", state_dbg, 4'd8);
    check("add_aluwb_reg_write", reg_write, 1'b1);
    check("add_aluwb_pc_write", pc_write, 1'b0);
    check("add_no_s_flags", flags_q, 4'b0000);
    tick();
    check("add_back_fetch", state_dbg, 4'd0);

    // SUBS R1,R2,R3 with Z set by the ALU
    instr = 32'hE0521003;
    tick();
    check("subs_decode_state", state_dbg, 4'd1);
    tick();
    check("subs_execr_state", state_dbg, 4'd6);
    check("subs_execr_alu_control", alu_control, 4'b0010);
    alu_flags = 4'b0100;
    #1;
    tick();
    check("subs_aluwb_state", state_dbg, 4'd8);
    check("subs_aluwb_flags", flags_q, 4'b0100);
    alu_flags = 4'b1001;
    tick();
    check("subs_fetch_flags", flags_q, 4'b0100);

    // BEQ taken (Z=1)
    instr = 32'h0A000002;
    tick();
    check("beq_decode_state", state_dbg, 4'd1);
    check("beq_decode_reg_src", reg_src, 2'b01);
    tick();
    check("beq_branch_state", state_dbg, 4'd9);
    check("beq_branch_pc_write", pc_write, 1'b1);
    check("beq_branch_imm_src", imm_src, 2'b10);
    check("beq_branch_srcb", alu_src_b, 2'b01);
    tick();
    check("beq_back_fetch", state_dbg, 4'd0);

    // CMP R1,R2: flags written, no register write-back
    instr = 32'hE1510002;
    alu_flags = 4'b0010;
    tick();
    tick();
    check("cmp_execr_state", state_dbg, 4'd6);
    tick();
    check("cmp_aluwb_state", state_dbg, 4'd8);
    check("cmp_aluwb_reg_write", reg_write, 1'b0);
    check("cmp_flags", flags_q, 4'b0010);
    tick();

    // LDR R0,[R1,#4]
    instr = 32'hE5910004;
    check("ldr_fetch_state", state_dbg, 4'd0);
    tick();
    check("ldr_decode_state", state_dbg, 4'd1);
    tick();
    check("ldr_memadr_state", state_dbg, 4'd2);
    check("ldr_memadr_alu_control", alu_control, 4'b0100);
    check("ldr_memadr_imm_src", imm_src, 2'b01);
    tick();
    check("ldr_memrd_state", state_dbg, 4'd3);
    check("ldr_memrd_adr_src", adr_src, 1'b1);
    check("ldr_memrd_reg_write", reg_write, 1'b0);
    tick();
    check("ldr_memwb_state", state_dbg, 4'd4);
    check("ldr_memwb_result_src", result_src, 2'b01);
    check("ldr_memwb_reg_write", reg_write, 1'b1);
    check("ldr_memwb_pc_write", pc_write, 1'b0);
    tick();
    check("ldr_back_fetch", state_dbg, 4'd0);

    // STR R0,[R1,#4]
    instr = 32'hE5810004;
    check("str_fetch_mem_write", mem_write, 1'b0);
    tick();
    check("str_decode_mem_write", mem_write, 1'b0);
    tick();
    check("str_memadr_state", state_dbg, 4'd2);
    check("str_memadr_mem_write", mem_write, 1'b0);
    tick();
    check("str_memwr_state", state_dbg, 4'd5);
    check("str_memwr_mem_write", mem_write, 1'b1);
    check("str_memwr_adr_src", adr_src, 1'b1);
    check("str_memwr_reg_write", reg_write, 1'b0);
    tick();
    check("str_back_fetch", state_dbg, 4'd0);
    check("str_after_mem_write", mem_write, 1'b0);

    // Second STR aborted by reset in MEMWR
    tick();
    tick();
    tick();
    check("abort_memwr_state", state_dbg, 4'd5);
    reset = 1'b1;
    #1;
    check("abort_mem_write", mem_write, 1'b0);
    tick();
    check("abort_next_state", state_dbg, 4'd0);
    check("abort_flags", flags_q, 4'b0000);
    reset = 1'b0;
    #1;

    // BEQ not taken (flags clear)
    instr = 32'h0A000002;
    tick();
    check("beqnt_decode_state", state_dbg, 4'd1);
    check("beqnt_decode_pc_write", pc_write, 1'b0);
    tick();
    check("beqnt_back_fetch", state_dbg, 4'd0);

    // BX LR
    instr = 32'hE12FFF1E;
    tick();
    check("bx_decode_state", state_dbg, 4'd1);
    tick();
    check("bx_state", state_dbg, 4'd10);
    check("bx_reg_src", reg_src, 2'b10);
    check("bx_pc_write", pc_write, 1'b1);
    check("bx_alu_control", alu_control, 4'b1101);
    check("bx_result_src", result_src, 2'b10);
    tick();
    check("bx_back_fetch", state_dbg, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
